// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter: region/state encodings,
// access sizes, default wait states and the alignment helper.
`default_nettype none

package mem_bus_pkg;

   typedef enum logic [1:0] {
      REGION_ROM    = 2'b00,
      REGION_RAM    = 2'b01,
      REGION_PERIF  = 2'b10,
      REGION_UNUSED = 2'b11
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_WAIT   = 2'b10,
      ST_RESP   = 2'b11
   } state_e;

   localparam logic [1:0] SIZE_BYTE   = 2'b00;
   localparam logic [1:0] SIZE_HALF   = 2'b01;
   localparam logic [1:0] SIZE_WORD   = 2'b10;
   localparam logic [1:0] SIZE_DOUBLE = 2'b11;

   localparam int DEF_ROM_WS   = 1;
   localparam int DEF_RAM_WS   = 0;
   localparam int DEF_PERIF_WS = 2;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
      logic mis;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = addr_lo[0];
         SIZE_WORD: mis = |addr_lo[1:0];
         default:   mis = |addr_lo;
      endcase
      return mis;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_region_decode.sv
// Combinational region decode and access legality check for one candidate request.
`default_nettype none

module mem_region_decode
   import mem_bus_pkg::*;
(
   input  logic [1:0] addr_hi,
   input  logic [2:0] addr_lo,
   input  logic [1:0] size,
   input  logic       we,
   output region_e    region,
   output logic       err
);

   always_comb begin
      region = region_e'(addr_hi);
      err    = (region == REGION_UNUSED)
             | ((region == REGION_ROM) & we)
             | is_misaligned(size, addr_lo);
   end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch/data) arbiter onto a single region-decoded memory bus with
// per-region wait states. Define MEM_ARB_ROUND_ROBIN_EN for round-robin grant.
`default_nettype none

module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ROM_WS   = DEF_ROM_WS,
   parameter int RAM_WS   = DEF_RAM_WS,
   parameter int PERIF_WS = DEF_PERIF_WS
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [63:0] d_rdata,
   output logic [31:0] mem_address,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   output logic        mem_write_en,
   output logic [1:0]  mem_size,
   output logic        ROM_select,
   output logic        RAM_select,
   output logic        PERIF_select,
   output logic        UNUSED_select
);

   localparam logic [3:0] ROM_WS4   = 4'(ROM_WS);
   localparam logic [3:0] RAM_WS4   = 4'(RAM_WS);
   localparam logic [3:0] PERIF_WS4 = 4'(PERIF_WS);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        gnt_data_q, gnt_data_d;
   logic        last_data_q, last_data_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic [63:0] wdata_q, wdata_d;
   region_e     region_q, region_d;
   logic        err_q, err_d;
   logic [63:0] rdata_q, rdata_d;

   logic        pick_data;
   logic [31:0] cand_addr;
   logic [1:0]  cand_size;
   logic        cand_we;
   region_e     cand_region;
   logic        cand_err;
   logic [3:0]  ws_cur;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // On a tie, the side that did not win last time gets the bus.
   assign pick_data = d_req & (~if_req | ~last_data_q);
`else
   assign pick_data = d_req;
`endif

   // Fetches are always aligned word reads.
   assign cand_addr = pick_data ? d_addr : if_addr;
   assign cand_size = pick_data ? d_size : SIZE_WORD;
   assign cand_we   = pick_data & d_we;

   mem_region_decode u_decode (
      .addr_hi (cand_addr[31:30]),
      .addr_lo (cand_addr[2:0]),
      .size    (cand_size),
      .we      (cand_we),
      .region  (cand_region),
      .err     (cand_err)
   );

   always_comb begin
      case (region_q)
         REGION_ROM:   ws_cur = ROM_WS4;
         REGION_RAM:   ws_cur = RAM_WS4;
         REGION_PERIF: ws_cur = PERIF_WS4;
         default:      ws_cur = 4'd0;
      endcase
   end

   // State register and transaction latches.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         gnt_data_q  <= 1'b0;
         last_data_q <= 1'b0;
         addr_q      <= 32'd0;
         size_q      <= 2'd0;
         we_q        <= 1'b0;
         wdata_q     <= 64'd0;
         region_q    <= REGION_ROM;
         err_q       <= 1'b0;
         rdata_q     <= 64'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_data_q  <= gnt_data_d;
         last_data_q <= last_data_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         region_q    <= region_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (if_req | d_req)
               state_d = cand_err ? ST_RESP : ST_ACCESS;
         end
         ST_ACCESS: state_d = (ws_cur != 4'd0) ? ST_WAIT : ST_RESP;
         ST_WAIT:   if (cnt_q == 4'd0) state_d = ST_RESP;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath updates: latch on grant, count wait states, capture read data.
   always_comb begin
      cnt_d       = cnt_q;
      gnt_data_d  = gnt_data_q;
      last_data_d = last_data_q;
      addr_d      = addr_q;
      size_d      = size_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      region_d    = region_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (if_req | d_req) begin
               gnt_data_d  = pick_data;
               last_data_d = pick_data;
               addr_d      = cand_addr;
               size_d      = cand_size;
               we_d        = cand_we;
               wdata_d     = pick_data ? d_wdata : 64'd0;
               region_d    = cand_region;
               err_d       = cand_err;
               rdata_d     = 64'd0;
            end
         end
         ST_ACCESS: begin
            if (ws_cur != 4'd0) cnt_d = ws_cur - 4'd1;
            else                rdata_d = mem_rdata;
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) rdata_d = mem_rdata;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: cnt_d = 4'd0;
      endcase
   end

   // Outputs decoded from the registered state so everything is zero outside a transaction.
   always_comb begin
      mem_address   = 32'd0;
      mem_wdata     = 64'd0;
      mem_write_en  = 1'b0;
      mem_size      = 2'd0;
      ROM_select    = 1'b0;
      RAM_select    = 1'b0;
      PERIF_select  = 1'b0;
      UNUSED_select = 1'b0;
      if_ack        = 1'b0;
      if_err        = 1'b0;
      if_rdata      = 32'd0;
      d_ack         = 1'b0;
      d_err         = 1'b0;
      d_rdata       = 64'd0;
      if ((state_q == ST_ACCESS) || (state_q == ST_WAIT)) begin
         mem_address   = addr_q;
         mem_wdata     = wdata_q;
         mem_write_en  = we_q;
         mem_size      = size_q;
         ROM_select    = (region_q == REGION_ROM);
         RAM_select    = (region_q == REGION_RAM);
         PERIF_select  = (region_q == REGION_PERIF);
         UNUSED_select = (region_q == REGION_UNUSED);
      end
      if (state_q == ST_RESP) begin
         if (gnt_data_q) begin
            d_ack   = 1'b1;
            d_err   = err_q;
            d_rdata = rdata_q;
         end else begin
            if_ack   = 1'b1;
            if_err   = err_q;
            if_rdata = rdata_q[31:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a table of single transactions plus
// arbitration, withdrawal and reset-in-wait sequences.
`default_nettype none

module tb_mem_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack, if_err;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_ack, d_err;
   logic [63:0] d_rdata;
   logic [31:0] mem_address;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_write_en;
   logic [1:0]  mem_size;
   logic        ROM_select, RAM_select, PERIF_select, UNUSED_select;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   mem_bus_arbiter #(.ROM_WS(1), .RAM_WS(0), .PERIF_WS(2)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_write_en(mem_write_en), .mem_size(mem_size),
      .ROM_select(ROM_select), .RAM_select(RAM_select),
      .PERIF_select(PERIF_select), .UNUSED_select(UNUSED_select)
   );

   wire [3:0] sels = {UNUSED_select, PERIF_select, RAM_select, ROM_select};
   wire       any_out = if_ack | if_err | (|if_rdata) | d_ack | d_err | (|d_rdata)
                      | (|mem_address) | (|mem_wdata) | mem_write_en | (|mem_size) | (|sels);

   typedef struct {
      logic        fetch;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          ack_cyc;
      logic        err;
      logic [3:0]  sel;     // {UNUSED,PERIF,RAM,ROM}
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge while the DUT is IDLE; that cycle is cycle 0.
   task automatic run_vec(input vec_t v, input string name);
      int         ack_cyc = 0;
      int         sel_cyc = 0;
      logic       err_o = 1'b0, multi = 1'b0, we_seen = 1'b0, wrong = 1'b0;
      logic [3:0] selmask = 4'd0;
      logic [1:0] size_o = 2'd0;
      logic [31:0] addr_o = 32'd0;
      logic [63:0] wdata_o = 64'd0, rdata_o = 64'd0;
      mem_rdata = v.rdata;
      if (v.fetch) begin
         if_req = 1'b1; if_addr = v.addr;
      end else begin
         d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
      end
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         if (sels != 4'd0) begin
            selmask |= sels;
            sel_cyc++;
            if ($countones(sels) != 1) multi = 1'b1;
            size_o = mem_size; addr_o = mem_address; wdata_o = mem_wdata;
         end
         if (mem_write_en) we_seen = 1'b1;
         if (v.fetch ? d_ack : if_ack) wrong = 1'b1;
         if (v.fetch ? if_ack : d_ack) begin
            ack_cyc = c;
            err_o   = v.fetch ? if_err : d_err;
            rdata_o = v.fetch ? {32'd0, if_rdata} : d_rdata;
            if_req = 1'b0; d_req = 1'b0;
            break;
         end
      end
      check({name, " ack_cycle"}, 64'(ack_cyc), 64'(v.ack_cyc));
      check({name, " err"}, 64'(err_o), 64'(v.err));
      check({name, " selects_seen"}, 64'(selmask), 64'(v.sel));
      check({name, " select_cycles"}, 64'(sel_cyc), v.err ? 64'd0 : 64'(v.ack_cyc - 1));
      check({name, " onehot"}, 64'(multi), 64'd0);
      check({name, " write_en"}, 64'(we_seen), 64'(v.we & ~v.err));
      check({name, " other_ack"}, 64'(wrong), 64'd0);
      if (!v.err) begin
         check({name, " mem_size"}, 64'(size_o), v.fetch ? 64'd2 : 64'(v.size));
         check({name, " mem_address"}, 64'(addr_o), 64'(v.addr));
         if (v.we) check({name, " mem_wdata"}, wdata_o, v.wdata);
         else      check({name, " rdata"}, rdata_o, v.fetch ? {32'd0, v.rdata[31:0]} : v.rdata);
      end
      @(negedge clock);
      check({name, " idle_after"}, 64'(any_out), 64'd0);
   endtask

   initial begin
      int         k;
      logic [3:0] order;
      int         ack_at[4];

      vecs[0] = '{1'b1, 1'b0, 2'b10, 32'h0000_0010, 64'h0, 64'h1111_2222_3333_4444, 3, 1'b0, 4'b0001};
      vecs[1] = '{1'b0, 1'b1, 2'b11, 32'h4000_0008, 64'hDEAD_BEEF_0123_4567, 64'h0, 2, 1'b0, 4'b0010};
      vecs[2] = '{1'b0, 1'b0, 2'b01, 32'h4000_0003, 64'h0, 64'h5555, 1, 1'b1, 4'b0000};
      vecs[3] = '{1'b0, 1'b1, 2'b10, 32'h0000_0100, 64'h77, 64'h0, 1, 1'b1, 4'b0000};
      vecs[4] = '{1'b0, 1'b0, 2'b00, 32'hC000_0000, 64'h0, 64'h9, 1, 1'b1, 4'b0000};
      vecs[5] = '{1'b0, 1'b0, 2'b10, 32'h8000_0004, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 4, 1'b0, 4'b0100};
      vecs[6] = '{1'b1, 1'b0, 2'b10, 32'h4000_0002, 64'h0, 64'h1, 1, 1'b1, 4'b0000};
      vecs[7] = '{1'b0, 1'b0, 2'b11, 32'h0000_0008, 64'h0, 64'h0102_0304_0506_0708, 3, 1'b0, 4'b0001};
      vecs[8] = '{1'b0, 1'b1, 2'b00, 32'h8000_0001, 64'h0000_0000_0000_00A5, 64'h0, 4, 1'b0, 4'b0100};
      vecs[9] = '{1'b0, 1'b0, 2'b11, 32'h4000_0004, 64'h0, 64'h3, 1, 1'b1, 4'b0000};

      reset = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
      d_size = 2'd0; d_addr = 32'd0; d_wdata = 64'd0; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset outputs", 64'(any_out), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      // Both requesters held for four transactions straight after reset.
      mem_rdata = 64'h0;
      if_req = 1'b1; if_addr = 32'h0000_0000;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h4000_0010;
      k = 0; order = 4'd0;
      for (int c = 1; c <= 40 && k < 4; c++) begin
         @(negedge clock);
         if (if_ack && d_ack) check("double ack", 64'd1, 64'd0);
         if (d_ack || if_ack) begin
            order[k]  = d_ack;
            ack_at[k] = c;
            k++;
         end
         if (k == 4) begin
            if_req = 1'b0; d_req = 1'b0;
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      check("arb ack count", 64'(k), 64'd4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check("arb order", 64'(order), 64'b0101);
      check("arb gap", 64'(ack_at[1] - ack_at[0]), 64'd4);
`else
      check("arb order", 64'(order), 64'b1111);
      check("arb gap", 64'(ack_at[1] - ack_at[0]), 64'd3);
`endif
      check("arb first ack", 64'(ack_at[0]), 64'd2);
      @(negedge clock);

      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Request withdrawn and inputs changed after the grant.
      mem_rdata = 64'h0BAD_F00D_1234_5678;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h4000_0000; d_wdata = 64'd0;
      @(negedge clock);
      check("withdraw addr", 64'(mem_address), 64'h4000_0000);
      check("withdraw sel", 64'(sels), 64'b0010);
      d_req = 1'b0; d_addr = 32'hC000_0000; d_size = 2'b01; d_we = 1'b1;
      @(negedge clock);
      check("withdraw ack", 64'(d_ack), 64'd1);
      check("withdraw err", 64'(d_err), 64'd0);
      check("withdraw rdata", d_rdata, 64'h0BAD_F00D_1234_5678);
      @(negedge clock);
      check("withdraw idle", 64'(any_out), 64'd0);

      // Reset during a peripheral wait state.
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h8000_0000;
      @(negedge clock);
      @(negedge clock);
      check("rst wait sel", 64'(PERIF_select), 64'd1);
      reset = 1'b1; d_req = 1'b0;
      @(negedge clock);
      check("rst abort outputs", 64'(any_out), 64'd0);
      reset = 1'b0;
      k = 0;
      repeat (4) begin
         @(negedge clock);
         if (d_ack || if_ack) k++;
      end
      check("rst no ack", 64'(k), 64'd0);
      run_vec(vecs[5], "post_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ROM_WS, 1, ROM wait-state cycles.
- RAM_WS, 0, RAM wait-state cycles.
- PERIF_WS, 2, peripheral wait-state cycles.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- if_req, in, 1, instruction-fetch request.
- if_addr, in, 32, fetch address.
- if_ack, out, 1, fetch done, one-cycle pulse.
- if_err, out, 1, fetch error, valid with if_ack.
- if_rdata, out, 32, fetched instruction, valid with if_ack.
- d_req, in, 1, data request.
- d_we, in, 1, 1 = store, 0 = load.
- d_size, in, 2, 00 byte, 01 half, 10 word, 11 double.
- d_addr, in, 32, data address.
- d_wdata, in, 64, store data.
- d_ack, out, 1, data done, one-cycle pulse.
- d_err, out, 1, data error, valid with d_ack.
- d_rdata, out, 64, load data, valid with d_ack.
- mem_address, out, 32, bus address.
- mem_wdata, out, 64, bus write data.
- mem_rdata, in, 64, bus read data.
- mem_write_en, out, 1, bus write strobe.
- mem_size, out, 2, bus access size; fetch forces 10.
- ROM_select, RAM_select, PERIF_select, UNUSED_select, out, 1 each, one-hot region selects.

Function
REQ-003 Region decode on addr[31:30] SHALL be: 00 ROM, 01 RAM, 10 PERIF, 11 UNUSED.
REQ-004 The FSM SHALL have states IDLE, ACCESS, WAIT and RESP.
REQ-005 IDLE SHALL grant when any request is high, latch the winner's address, size, we and wdata, then go to ACCESS; an error access SHALL go to RESP instead.
REQ-006 An access SHALL be an error if the region is UNUSED, the access is a store to ROM, or the address is misaligned to its size.
REQ-007 In ACCESS and WAIT the block SHALL drive mem_* from the latched values and assert exactly one region select.
REQ-008 mem_write_en SHALL be high only when the latched we is 1.
REQ-009 ACCESS SHALL go to WAIT when the region's wait-state count is nonzero, else to RESP.
REQ-010 WAIT SHALL count down a 4-bit counter loaded with the wait-state count minus 1, and go to RESP on zero.
REQ-011 mem_rdata SHALL be registered on the last ACCESS or WAIT cycle.
REQ-012 In RESP the block SHALL pulse the granted requester's ack for one cycle, together with err and registered rdata (if_rdata = rdata[31:0]); then the FSM SHALL go to IDLE unconditionally.
REQ-013 Latency SHALL be: request high in IDLE cycle 0, ack in cycle 2+WS; an error access acks in cycle 1.
REQ-014 Requesters SHALL hold req and all inputs stable until ack; changes made mid-transaction SHALL be ignored.
REQ-015 Outside ACCESS/WAIT, all selects and mem_write_en SHALL be 0, and mem_address and mem_wdata SHALL be 0.
REQ-016 A withdrawn request SHALL not be dropped: the latched transaction completes.
REQ-017 The non-granted requester SHALL see no ack.
REQ-018 Back-to-back service SHALL pass through one IDLE cycle between transactions.

Reset
REQ-019 Reset SHALL force IDLE, counter 0 and round-robin pointer to "fetch last".
REQ-020 Reset SHALL clear every output to 0; reset mid-transaction SHALL abort it with no ack.

Configuration
REQ-021 With MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL grant the requester not granted last.
REQ-022 Without MEM_ARB_ROUND_ROBIN_EN, d_req SHALL always win over if_req.

Structure
REQ-023 Package mem_bus_pkg SHALL hold the region enum, state enum, size encodings and default wait-state constants.
REQ-024 Address decode plus error check SHALL be the combinational sub-module mem_region_decode.

Verification
REQ-025 Fetch 0x0000_0010 with ROM_WS=1 -> ROM_select in cycles 1-2; if_ack in cycle 3 with if_rdata = mem_rdata[31:0]; err 0.
REQ-026 Store double 0x4000_0008 with wdata 0xDEAD_BEEF_0123_4567 -> RAM_select and mem_write_en in cycle 1, mem_size 11, d_ack in cycle 2.
REQ-027 Load half from 0x4000_0003 -> d_ack plus d_err in cycle 1; no select ever asserted.
REQ-028 Store to 0x0000_0100 and access 0xC000_0000 -> d_err=1; mem_write_en never high.
REQ-029 if_req and d_req held together for four transactions -> order D,D,D,D without the macro, D,F,D,F with it.
REQ-030 Reset asserted in a PERIF WAIT cycle -> next cycle IDLE, all outputs 0, no ack; the following request is serviced normally.
